// File: rtl/oamdma_pkg.sv
// Shared types and constants for the sprite-DMA controller.
package oamdma_pkg;

  // FSM state codes; 3-bit encoding is visible on debug taps.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHalt  = 3'd1,
    StAlign = 3'd2,
    StRead  = 3'd3,
    StWrite = 3'd4
  } oamdma_state_e;

  // CPU address of the DMA trigger register, used by the CPU address decoder.
  localparam logic [15:0] Reg4014 = 16'h4014;

  // Last byte index of the 256-byte page.
  localparam logic [7:0] CntLast = 8'hFF;

endpackage

// File: rtl/oamdma.sv
// Sprite-DMA controller: a CPU write to $4014 halts the CPU and copies the
// 256-byte page {page,8'h00}..{page,8'hFF} into OAM, one read/write pair per byte.
// Optional build macro OAMDMA_ALIGN_EN adds a get/put phase tracker so that reads
// land on get cycles and writes on put cycles, inserting one alignment cycle when needed.
module oamdma
  import oamdma_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        wr4014_i,
  input  logic [7:0]  regwdata_i,
  input  logic        cpurd_i,
  input  logic [7:0]  memrdata_i,
  output logic        halt_o,
  output logic        dmareq_o,
  output logic [15:0] dmaaddr_o,
  output logic        dmawr2004_o,
  output logic [7:0]  dmawdata_o,
  output logic        busy_o
);

  oamdma_state_e state_q, state_d;
  logic [7:0]    page_q, page_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    databuf_q, databuf_d;

`ifdef OAMDMA_ALIGN_EN
  // 0 = get cycle, 1 = put cycle; free-running from reset on every tick.
  logic phase_q;

  // Phase tracker toggles once per CPU cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
    end else if (tick_i) begin
      phase_q <= ~phase_q;
    end
  end
`endif

  // State, page, byte counter and read buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      page_q    <= 8'h00;
      cnt_q     <= 8'h00;
      databuf_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      cnt_q     <= cnt_d;
      databuf_q <= databuf_d;
    end
  end

  // Next-state logic; nothing moves unless the CPU-cycle enable is high.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    cnt_d     = cnt_q;
    databuf_d = databuf_q;
    if (tick_i) begin
      case (state_q)
        StIdle: begin
          if (wr4014_i) begin
            page_d  = regwdata_i;
            cnt_d   = 8'h00;
            state_d = StHalt;
          end
        end
        StHalt: begin
          // Halt only takes effect on a CPU read cycle; writes keep us waiting.
          if (cpurd_i) begin
`ifdef OAMDMA_ALIGN_EN
            // Halt on a get cycle means the next cycle is put: burn it to realign.
            state_d = phase_q ? StRead : StAlign;
`else
            state_d = StRead;
`endif
          end
        end
        StAlign: begin
          state_d = StRead;
        end
        StRead: begin
          databuf_d = memrdata_i;
          state_d   = StWrite;
        end
        StWrite: begin
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_q == CntLast) ? StIdle : StRead;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so they hold for the whole CPU cycle.
  always_comb begin
    halt_o      = (state_q != StIdle);
    busy_o      = (state_q != StIdle);
    dmareq_o    = (state_q == StRead);
    dmawr2004_o = (state_q == StWrite);
    dmaaddr_o   = {page_q, cnt_q};
    dmawdata_o  = databuf_q;
  end

endmodule
